// File: rtl/hidden_delta.sv
// hidden_delta: back-propagation delta stage for one hidden layer.
// Captures a full input bundle, then serially accumulates
// delta[j] = sum_k w[k][j]*d[k] over the NN next-layer neurons (one k per
// cycle, all NC lanes in parallel). It then presents the deltas packed
// above the pass-through activations.
// Optional feature macro: HIDDEN_DELTA_RELU_EN. When defined, delta[j] is
// masked by the ReLU derivative (z[j] > 0). When undefined, the activation
// is linear and the z field is ignored.
module hidden_delta #(
   parameter  int NP = 4,
   parameter  int NC = 4,
   parameter  int NN = 4,
   parameter  int WC = 4,
   parameter  int WD = 4,
   localparam int WA = $clog2(NN) + WC + WD,
   localparam int IW = NP*WD + NC*WD + NN*WD + NN*NC*WC,
   localparam int OW = NP*WD + NC*WA
) (
   input  logic          iCLK,
   input  logic          iRST,
   input  logic          iValid_AS,
   output logic          oReady_AS,
   input  logic [IW-1:0] iData_AS,
   output logic          oValid_BS,
   input  logic          iReady_BS,
   output logic [OW-1:0] oData_BS
);

   localparam int KW   = (NN > 1) ? $clog2(NN) : 1;
   localparam int ZOFF = NP*WD;
   localparam int DOFF = ZOFF + NC*WD;
   localparam int WOFF = DOFF + NN*WD;
   localparam logic [KW-1:0] KLAST = KW'(NN-1);

   typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

   state_t                  state_q, state_d;
   logic [KW-1:0]           k_q, k_d;
   logic signed [WA-1:0]    acc_q [NC];
   logic signed [WA-1:0]    acc_d [NC];
   logic signed [WC+WD-1:0] prod  [NC];
   logic                    load;

   logic [NP*WD-1:0]        a_q;
   logic signed [WD-1:0]    d_q [NN];
   logic signed [WC-1:0]    w_q [NN][NC];
`ifdef HIDDEN_DELTA_RELU_EN
   logic signed [WD-1:0]    z_q [NC];
`else
   logic                    unusedZ;
   assign unusedZ = ^iData_AS[DOFF-1:ZOFF];
`endif

   // One full-precision product per lane for the current next-layer neuron k
   always_comb begin
      for (int j = 0; j < NC; j++) begin
         prod[j] = (WC+WD)'(w_q[k_q][j]) * (WC+WD)'(d_q[k_q]);
      end
   end

   // Next-state, accumulator update and handshake outputs
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      load      = 1'b0;
      oReady_AS = 1'b0;
      oValid_BS = 1'b0;
      for (int j = 0; j < NC; j++) begin
         acc_d[j] = acc_q[j];
      end
      unique case (state_q)
         IDLE: begin
            oReady_AS = 1'b1;
            if (iValid_AS) begin
               load    = 1'b1;
               state_d = ACC;
               k_d     = '0;
               for (int j = 0; j < NC; j++) begin
                  acc_d[j] = '0;
               end
            end
         end
         ACC: begin
            for (int j = 0; j < NC; j++) begin
               acc_d[j] = acc_q[j] + WA'(prod[j]);
            end
            if (k_q == KLAST) begin
               state_d = OUT;
`ifdef HIDDEN_DELTA_RELU_EN
               for (int j = 0; j < NC; j++) begin
                  if (z_q[j][WD-1] || (z_q[j] == '0)) begin
                     acc_d[j] = '0;
                  end
               end
`endif
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         OUT: begin
            oValid_BS = 1'b1;
            oReady_AS = iReady_BS;
            if (iReady_BS) begin
               if (iValid_AS) begin
                  load    = 1'b1;
                  state_d = ACC;
                  k_d     = '0;
                  for (int j = 0; j < NC; j++) begin
                     acc_d[j] = '0;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, index counter and accumulators; reset discards any in-flight work
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q <= IDLE;
         k_q     <= '0;
         for (int j = 0; j < NC; j++) begin
            acc_q[j] <= '0;
         end
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         for (int j = 0; j < NC; j++) begin
            acc_q[j] <= acc_d[j];
         end
      end
   end

   // Capture the whole input bundle so the source may change the bus afterwards
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         a_q <= '0;
         for (int k = 0; k < NN; k++) begin
            d_q[k] <= '0;
            for (int j = 0; j < NC; j++) begin
               w_q[k][j] <= '0;
            end
         end
`ifdef HIDDEN_DELTA_RELU_EN
         for (int j = 0; j < NC; j++) begin
            z_q[j] <= '0;
         end
`endif
      end else if (load) begin
         a_q <= iData_AS[NP*WD-1:0];
         for (int k = 0; k < NN; k++) begin
            d_q[k] <= iData_AS[DOFF + k*WD +: WD];
            for (int j = 0; j < NC; j++) begin
               w_q[k][j] <= iData_AS[WOFF + (k*NC + j)*WC +: WC];
            end
         end
`ifdef HIDDEN_DELTA_RELU_EN
         for (int j = 0; j < NC; j++) begin
            z_q[j] <= iData_AS[ZOFF + j*WD +: WD];
         end
`endif
      end
   end

   // Output packing: activations in the low bits, deltas above them
   always_comb begin
      oData_BS            = '0;
      oData_BS[NP*WD-1:0] = a_q;
      for (int j = 0; j < NC; j++) begin
         oData_BS[NP*WD + j*WA +: WA] = acc_q[j];
      end
   end

endmodule

// File: tb/tb_hidden_delta.sv
// Testbench for hidden_delta: table-driven vectors (directed and random)
// checked against a plain-arithmetic reference model, plus hand-written
// sequences for reset mid-accumulation, backpressure and back-to-back flow.
module tb_hidden_delta;

   localparam int NP = 4;
   localparam int NC = 4;
   localparam int NN = 4;
   localparam int WC = 4;
   localparam int WD = 4;
   localparam int WA = 10;
   localparam int IW = NP*WD + NC*WD + NN*WD + NN*NC*WC;
   localparam int OW = NP*WD + NC*WA;

   typedef struct {
      string         name;
      logic [15:0]   a;
      logic [15:0]   z;
      logic [15:0]   d;
      logic [63:0]   w;
      logic [39:0]   ex;
   } vec_t;

   logic          iCLK      = 1'b0;
   logic          iRST      = 1'b1;
   logic          iValid_AS = 1'b0;
   logic          iReady_BS = 1'b0;
   logic [IW-1:0] iData_AS  = '0;
   logic          oReady_AS;
   logic          oValid_BS;
   logic [OW-1:0] oData_BS;

   int errors = 0;
   int checks = 0;

   vec_t tbl [12];
   vec_t bb  [5];

   hidden_delta #(.NP(NP), .NC(NC), .NN(NN), .WC(WC), .WD(WD)) dut (
      .iCLK      (iCLK),
      .iRST      (iRST),
      .iValid_AS (iValid_AS),
      .oReady_AS (oReady_AS),
      .iData_AS  (iData_AS),
      .oValid_BS (oValid_BS),
      .iReady_BS (iReady_BS),
      .oData_BS  (oData_BS)
   );

   // Free-running clock
   always #5 iCLK = ~iCLK;

   // Reference: delta[j] = mask[j] * sum_k w[k][j]*d[k] in plain integers
   function automatic logic [39:0] model(input logic [15:0] z, input logic [15:0] d,
                                         input logic [63:0] w);
      logic [39:0] r;
      int          s;
      logic        reluOn;
`ifdef HIDDEN_DELTA_RELU_EN
      reluOn = 1'b1;
`else
      reluOn = 1'b0;
`endif
      r = '0;
      for (int j = 0; j < NC; j++) begin
         s = 0;
         for (int k = 0; k < NN; k++) begin
            s += int'($signed(w[(k*NC + j)*WC +: WC])) * int'($signed(d[k*WD +: WD]));
         end
         if (reluOn && ($signed(z[j*WD +: WD]) <= 0)) s = 0;
         r[j*WA +: WA] = s[WA-1:0];
      end
      return r;
   endfunction

   function automatic logic [IW-1:0] randBus();
      logic [127:0] t;
      t = {$urandom, $urandom, $urandom, $urandom};
      return t[IW-1:0];
   endfunction

   function automatic vec_t randVec(input string name);
      vec_t v;
      logic [63:0] t;
      v.name = name;
      t = {$urandom, $urandom};
      v.a = t[15:0];
      v.z = t[31:16];
      v.d = t[47:32];
      v.w = {$urandom, $urandom};
      v.ex = model(v.z, v.d, v.w);
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Present a bundle and complete the input handshake; returns at the negedge after it
   task automatic applyStimulus(input vec_t v);
      int guard = 0;
      iValid_AS = 1'b1;
      iData_AS  = {v.w, v.d, v.z, v.a};
      while (!oReady_AS && guard < 50) begin
         @(negedge iCLK);
         guard++;
      end
      checkOutput({v.name, "_accepted"}, 64'(guard < 50), 64'd1);
      @(posedge iCLK);
      @(negedge iCLK);
      iValid_AS = 1'b0;
      iData_AS  = randBus();
   endtask

   task automatic waitValid(output int lat);
      lat = 0;
      while (!oValid_BS && lat < 50) begin
         @(negedge iCLK);
         lat++;
      end
   endtask

   task automatic drain();
      iReady_BS = 1'b1;
      @(posedge iCLK);
      @(negedge iCLK);
      iReady_BS = 1'b0;
   endtask

   task automatic runVector(input vec_t v);
      int lat;
      applyStimulus(v);
      checkOutput({v.name, "_readyLowInAcc"}, 64'(oReady_AS), 64'd0);
      waitValid(lat);
      checkOutput({v.name, "_latency"}, 64'(lat), 64'(NN));
      checkOutput({v.name, "_data"}, 64'(oData_BS), 64'({v.ex, v.a}));
      drain();
      checkOutput({v.name, "_idleAfterDrain"}, 64'(oValid_BS), 64'd0);
   endtask

   initial begin
      int lat;
      int idx;
      int outCnt;
      int lastOut;
      int cyc;
      logic inHs;
      logic outHs;
      vec_t v;

      // Directed entries with hand-computed results
      tbl[0] = '{"basicMac",   16'hA5C3, 16'h1111, 16'h4321, 64'h1111_1111_1111_1111,
                 {10'd10, 10'd10, 10'd10, 10'd10}};
      tbl[1] = '{"negNeg",     16'h0F0F, 16'h1111, 16'h8888, 64'h8888_8888_8888_8888,
                 {10'd256, 10'd256, 10'd256, 10'd256}};
      tbl[2] = '{"negPos",     16'hFFFF, 16'h7777, 16'h8888, 64'h7777_7777_7777_7777,
                 {10'd800, 10'd800, 10'd800, 10'd800}};
`ifdef HIDDEN_DELTA_RELU_EN
      tbl[3] = '{"reluMask",   16'h1234, 16'h1D05, 16'h0321, 64'h1111_1111_1111_1111,
                 {10'd6, 10'd0, 10'd0, 10'd6}};
`else
      tbl[3] = '{"reluMask",   16'h1234, 16'h1D05, 16'h0321, 64'h1111_1111_1111_1111,
                 {10'd6, 10'd6, 10'd6, 10'd6}};
`endif
      for (int i = 4; i < 12; i++) begin
         tbl[i] = randVec($sformatf("rand%0d", i));
      end
      for (int i = 0; i < 5; i++) begin
         bb[i] = randVec($sformatf("b2b%0d", i));
      end

      // Reset state
      repeat (3) @(negedge iCLK);
      iRST = 1'b0;
      #1;
      checkOutput("reset_valid", 64'(oValid_BS), 64'd0);
      checkOutput("reset_ready", 64'(oReady_AS), 64'd1);
      checkOutput("reset_data",  64'(oData_BS),  64'd0);
      @(negedge iCLK);

      // Table-driven vectors
      for (int i = 0; i < 12; i++) begin
         runVector(tbl[i]);
      end

      // Backpressure: hold off downstream for 10 cycles while in OUT
      v = randVec("backpressure");
      applyStimulus(v);
      waitValid(lat);
      checkOutput("bp_latency", 64'(lat), 64'(NN));
      for (int i = 0; i < 10; i++) begin
         checkOutput($sformatf("bp_valid%0d", i), 64'(oValid_BS), 64'd1);
         checkOutput($sformatf("bp_data%0d", i),  64'(oData_BS),  64'({v.ex, v.a}));
         checkOutput($sformatf("bp_ready%0d", i), 64'(oReady_AS), 64'd0);
         @(negedge iCLK);
      end
      drain();

      // Reset two cycles into accumulation discards the bundle
      v = randVec("aborted");
      applyStimulus(v);
      @(negedge iCLK);
      @(negedge iCLK);
      #2 iRST = 1'b1;
      #1;
      checkOutput("midReset_validDuring", 64'(oValid_BS), 64'd0);
      @(negedge iCLK);
      iRST = 1'b0;
      #1;
      checkOutput("midReset_valid", 64'(oValid_BS), 64'd0);
      checkOutput("midReset_ready", 64'(oReady_AS), 64'd1);
      checkOutput("midReset_data",  64'(oData_BS),  64'd0);
      @(negedge iCLK);
      runVector(randVec("afterReset"));

      // Back-to-back: continuous valid and ready
      iReady_BS = 1'b1;
      iValid_AS = 1'b1;
      iData_AS  = {bb[0].w, bb[0].d, bb[0].z, bb[0].a};
      idx = 0;
      outCnt = 0;
      lastOut = -1;
      cyc = 0;
      while (outCnt < 5 && cyc < 200) begin
         inHs  = oReady_AS && iValid_AS;
         outHs = oValid_BS && iReady_BS;
         if (outHs) begin
            checkOutput($sformatf("b2b_data%0d", outCnt), 64'(oData_BS),
                        64'({bb[outCnt].ex, bb[outCnt].a}));
            if (lastOut >= 0) begin
               checkOutput($sformatf("b2b_gap%0d", outCnt), 64'(cyc - lastOut), 64'(NN + 1));
            end
            if (idx < 5) begin
               checkOutput($sformatf("b2b_capture%0d", outCnt), 64'(inHs), 64'd1);
            end
            lastOut = cyc;
            outCnt++;
         end
         if (inHs) idx++;
         @(posedge iCLK);
         @(negedge iCLK);
         cyc++;
         if (inHs) begin
            if (idx < 5) iData_AS = {bb[idx].w, bb[idx].d, bb[idx].z, bb[idx].a};
            else begin
               iValid_AS = 1'b0;
               iData_AS  = randBus();
            end
         end
      end
      checkOutput("b2b_outputs", 64'(outCnt), 64'd5);
      iReady_BS = 1'b0;
      iValid_AS = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hidden_delta.md
# hidden_delta

Back-propagation stage for one hidden layer; it sits directly upstream of the bias/weight update stage. It accepts the next layer's deltas, the transposed next-layer weights, this layer's pre-activations and the previous layer's activations. It computes each hidden neuron's delta as a serial multiply-accumulate over the next layer's neurons. It emits the delta vector bundled with the pass-through activations, in exactly the packing the update stage consumes.

## Interface
- NP, 4: neurons in previous layer (pass-through activations)
- NC, 4: neurons in this layer (deltas produced)
- NN, 4: neurons in next layer (accumulation length), ≥1
- WC, 4: weight width, signed
- WD, 4: activation/delta width, signed
- Derived: WA = $clog2(NN)+WC+WD, the accumulator/delta width
- iCLK  in  1  clock, rising edge
- iRST  in  1  asynchronous, active-high reset
- iValid_AS  in  1  input bundle valid
- oReady_AS  out  1  input bundle accepted when high with iValid_AS
- iData_AS  in  NP*WD+NC*WD+NN*WD+NN*NC*WC  LSB first:
  - activations a[p] at p*WD
  - pre-activations z[j]
  - next deltas d[k]
  - weights w[k][j] at (k*NC+j)*WC
- oValid_BS  out  1  output bundle valid
- iReady_BS  in  1  downstream ready
- oData_BS  out  NP*WD+NC*WA  LSB first:
  - a[p] unchanged at p*WD
  - delta[j] at NP*WD+j*WA

## Operation
- Function: delta[j] = mask[j] · Σ_{k=0..NN-1} w[k][j]·d[k].
  - Signed two's-complement arithmetic throughout.
  - Products are WC+WD bits, sign-extended to WA.
  - Accumulation is WA bits and never overflows by construction.
- Input handshake at edge T:
  - The whole iData_AS word is captured into internal registers.
  - The input bus may change afterwards.
- FSM states:
  - IDLE: oReady_AS=1. On handshake → ACC, with k=0 and all NC accumulators cleared.
  - ACC: each cycle, acc[j] += w[k][j]·d[k] for all j in parallel; k increments. When k==NN-1 → OUT, with mask applied on the same edge.
  - OUT: oValid_BS=1 and oData_BS stable.
    - On output handshake with no new input → IDLE.
    - oReady_AS = iReady_BS in OUT. A simultaneous input and output handshake captures the new bundle and goes straight to ACC (back-to-back).
- Counter k is $clog2(NN) bits (min 1) and never wraps past NN-1.
- Reset, asynchronous at any time including mid-ACC:
  - State → IDLE, k=0, accumulators=0.
  - oValid_BS=0, oReady_AS=1 immediately after reset deasserts.
  - oData_BS=0.
  - The in-flight bundle is discarded.

## Timing
- Latency: input handshake at edge T → oValid_BS high from edge T+NN until the output handshake.
- Throughput: one bundle per NN+1 cycles with continuous iReady_BS; otherwise limited by downstream stall.
- oValid_BS, once high, stays high and oData_BS stays constant until iReady_BS is sampled high.
- oReady_AS is 0 throughout ACC; iValid_AS during ACC is ignored and not lost, because the source must hold it.
- No combinational path from iValid_AS to oValid_BS. oReady_AS depends combinationally on iReady_BS only in OUT.

## Configuration
- HIDDEN_DELTA_RELU_EN
  - Defined: mask[j] = (z[j] > 0). delta[j] is forced to 0 when z[j] ≤ 0, including z[j]=0; this is the ReLU derivative.
  - Undefined: mask[j]=1 (linear activation). The z field stays in the input packing but is ignored, and no comparator logic is built.

## Test plan
- Reset mid-ACC:
  - Stimulus: assert iRST two cycles after a handshake with NN=4.
  - Response: oValid_BS=0 and oReady_AS=1 after release. The next bundle produces a correct result, with no contamination from the aborted accumulation.
- Basic MAC, NC=1, NN=4, WD=WC=4, macro off:
  - Stimulus: d={1,2,3,4}, w={1,1,1,1}.
  - Response: delta=10, with oValid_BS rising exactly 4 edges after the handshake.
- Signed extremes:
  - Stimulus: d[k]=-8, w[k][j]=-8 for all k, NN=4.
  - Response: delta[j]=256 in WA=10 bits, with no overflow. Using d=-8 and w=7 gives -224.
- ReLU mask, macro on:
  - Stimulus: z={5,0,-3,1} with every raw sum equal to 6.
  - Response: deltas={6,0,0,6}. With the macro off, the same stimulus gives {6,6,6,6}.
- Backpressure:
  - Stimulus: hold iReady_BS=0 for 10 cycles while in OUT.
  - Response: oValid_BS stays high and oData_BS stays unchanged. oReady_AS=0 throughout, and the activations pass through bit-exact.
- Back-to-back:
  - Stimulus: iValid_AS and iReady_BS held high continuously.
  - Response: one output every NN+1 cycles. Each new bundle is captured in the same cycle as the previous output handshake, and results appear in order.
